// File: rtl/hybrid_median_filter_p.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hybrid_median_filter_p
//   Streaming 3x3 hybrid-median denoiser. Pixels arrive in raster order with
//   their coordinates. Two chained line buffers supply the rows above. A 3x3
//   window feeds a three-stage pipeline:
//     S1: line buffer read and window load
//     S2: median5 of the diagonal cross and of the orthogonal cross
//     S3: mode/border select and output register
//   out_valid is high 3 cycles after the accepted input that completes the
//   window around centre (row-1, col-1).
//
// Ports
//   clk        pixel clock
//   rst        synchronous, active-high reset
//   in_valid   pix/row/col valid this cycle
//   pix        input pixel (PIX_W)
//   row, col   coordinates of pix (COORD_W)
//   mode       0 bypass, 1 hybrid, 2 cross median, 3 same as 1
//   out_valid  pixout/rowout/colout valid
//   pixout     filtered centre pixel
//   rowout     row of the output centre pixel
//   colout     column of the output centre pixel
// -----------------------------------------------------------------------------
module hybrid_median_filter_p #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 13,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   pix,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [1:0]         mode,
  output logic               out_valid,
  output logic [PIX_W-1:0]   pixout,
  output logic [COORD_W-1:0] rowout,
  output logic [COORD_W-1:0] colout
);

  localparam logic [COORD_W-1:0] ROW_LIM     = COORD_W'(IMG_H);
  localparam logic [COORD_W-1:0] COL_LIM     = COORD_W'(IMG_W);
  localparam logic [1:0]         MODE_BYPASS = 2'd0;
  localparam logic [1:0]         MODE_CROSS  = 2'd2;

  // Median of three: clamp c into [min(a,b), max(a,b)].
  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    logic [PIX_W-1:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c > hi)      return hi;
    else if (c < lo) return lo;
    else             return c;
  endfunction

  // Median of five via a fixed compare-swap network; result is always an input.
  function automatic logic [PIX_W-1:0] med5(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c,
                                            input logic [PIX_W-1:0] d,
                                            input logic [PIX_W-1:0] e);
    logic [PIX_W-1:0] v [5];
    logic [PIX_W-1:0] t;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t      = v[j];
          v[j]   = v[j+1];
          v[j+1] = t;
        end
      end
    end
    return v[2];
  endfunction

  logic              accept, frame_start, emit, armed;
  logic [ADDR_W-1:0] addr;

  logic [PIX_W-1:0]  lb0 [IMG_W];   // row r-1
  logic [PIX_W-1:0]  lb1 [IMG_W];   // row r-2
  logic [PIX_W-1:0]  win [3][3];    // [0]=row r-2 .. [2]=row r; [x][2] newest column

  logic               s1_valid;
  logic [1:0]         s1_mode;
  logic [COORD_W-1:0] s1_row, s1_col;

  logic               s2_valid, s2_border;
  logic [1:0]         s2_mode;
  logic [PIX_W-1:0]   s2_m45, s2_m90, s2_centre;
  logic [COORD_W-1:0] s2_row, s2_col;

  logic [PIX_W-1:0]   sel;

  assign accept      = in_valid && (row < ROW_LIM) && (col < COL_LIM);
  assign frame_start = accept && (row == '0) && (col == '0);
  // armed masks stale line-buffer data after reset until a frame start.
  assign emit        = accept && armed && (row != '0) && (col != '0);
  assign addr        = col[ADDR_W-1:0];

  // NOTE: line buffers carry no reset; stale contents are masked by the armed flag instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[addr] <= pix;
      lb1[addr] <= lb0[addr];
    end
  end

  // S1: window shift with the registered line-buffer read landing in the
  // newest column, plus coordinates/mode of the centre being formed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      armed    <= 1'b0;
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else begin
      s1_valid <= emit;
      if (frame_start) armed <= 1'b1;
      if (accept) begin
        // NOTE: non-blocking so each tap takes its neighbour's pre-edge value.
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1[addr];
        win[1][2] <= lb0[addr];
        win[2][2] <= pix;
        s1_mode   <= mode;
        s1_row    <= row - COORD_W'(1);
        s1_col    <= col - COORD_W'(1);
      end
    end
  end

  // S2: the two cross medians.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_border <= 1'b0;
      s2_mode   <= '0;
      s2_m45    <= '0;
      s2_m90    <= '0;
      s2_centre <= '0;
      s2_row    <= '0;
      s2_col    <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_m45    <= med5(win[0][0], win[0][2], win[2][0], win[2][2], win[1][1]);
      s2_m90    <= med5(win[0][1], win[1][0], win[1][2], win[2][1], win[1][1]);
      s2_centre <= win[1][1];
      s2_border <= (s1_row == '0) || (s1_col == '0);
      s2_mode   <= s1_mode;
      s2_row    <= s1_row;
      s2_col    <= s1_col;
    end
  end

  // S3 select; border centres pass through regardless of mode.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = med3(s2_m45, s2_m90, s2_centre);
    if (s2_border || s2_mode == MODE_BYPASS) sel = s2_centre;
    else if (s2_mode == MODE_CROSS)          sel = s2_m90;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pixout    <= '0;
      rowout    <= '0;
      colout    <= '0;
    end else begin
      out_valid <= s2_valid;
      pixout    <= sel;
      rowout    <= s2_row;
      colout    <= s2_col;
    end
  end

endmodule

// File: tb/tb_hybrid_median_filter_p.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hybrid_median_filter_p
//   Scoreboard bench for hybrid_median_filter_p on an 8x6 frame. The driver
//   keeps a picture of the accepted frame and pushes the expected output for
//   each emitting pixel; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_hybrid_median_filter_p;

  localparam int PW = 8;
  localparam int CW = 13;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, in_valid;
  logic [PW-1:0] pix;
  logic [CW-1:0] row, col;
  logic [1:0]    mode;
  logic          out_valid;
  logic [PW-1:0] pixout;
  logic [CW-1:0] rowout, colout;

  always #5 clk = ~clk;

  hybrid_median_filter_p #(
    .PIX_W(PW), .COORD_W(CW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pix(pix), .row(row), .col(col),
    .mode(mode), .out_valid(out_valid), .pixout(pixout), .rowout(rowout),
    .colout(colout)
  );

  typedef struct { int r; int c; int p; int due; } exp_t;
  typedef struct { int r; int c; int p; } out_t;

  exp_t sb[$];
  out_t cap_q[$];
  out_t gold_q[$];
  int   cap_img [H][W];
  int   frame   [H][W];   // stimulus picture
  int   img     [H][W];   // model: what has been accepted so far
  bit   armed_m;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Median by definition: the value with at most n/2 inputs below it and
  // more than n/2 inputs at or below it.
  function automatic int med_of(input int v[5], input int n);
    int lt, le;
    for (int i = 0; i < n; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < n; j++) begin
        if (v[j] <  v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= n / 2 && le > n / 2) return v[i];
    end
    return -1;
  endfunction

  function automatic int model_out(input int r, input int c, input int m);
    int o[5];
    int d[5];
    int t[5];
    int m90, m45;
    if (r == 0 || c == 0 || m == 0) return img[r][c];
    o[0] = img[r-1][c]; o[1] = img[r+1][c]; o[2] = img[r][c-1];
    o[3] = img[r][c+1]; o[4] = img[r][c];
    m90 = med_of(o, 5);
    if (m == 2) return m90;
    d[0] = img[r-1][c-1]; d[1] = img[r-1][c+1]; d[2] = img[r+1][c-1];
    d[3] = img[r+1][c+1]; d[4] = img[r][c];
    m45 = med_of(d, 5);
    t[0] = m45; t[1] = m90; t[2] = img[r][c]; t[3] = 0; t[4] = 0;
    return med_of(t, 3);
  endfunction

  // One input cycle; updates the model and scoreboard for what the DUT will see.
  task automatic drive(input bit v, input int r, input int c, input int p,
                       input int m, input bit rs);
    @(posedge clk);
    #1;
    rst      = rs;
    in_valid = v;
    row      = CW'(r);
    col      = CW'(c);
    pix      = PW'(p);
    mode     = 2'(m);
    if (rs) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      armed_m = 1'b0;
    end else if (v && r < H && c < W) begin
      img[r][c] = p;
      if (r == 0 && c == 0) armed_m = 1'b1;
      else if (armed_m && r >= 1 && c >= 1) begin
        exp_t e;
        e.r   = r - 1;
        e.c   = c - 1;
        e.p   = model_out(r - 1, c - 1, m);
        e.due = cyc + 3;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 1, 1'b0);
  endtask

  // Non-accepted cycle: either in_valid low or coordinates outside the frame.
  task automatic gap_cycle();
    case ($urandom_range(0, 2))
      0: drive(1'b0, $urandom_range(0, H-1), $urandom_range(0, W-1), $urandom_range(0, 255), 2, 1'b0);
      1: drive(1'b1, H + $urandom_range(0, 3), $urandom_range(0, W-1), $urandom_range(0, 255), 0, 1'b0);
      default: drive(1'b1, $urandom_range(0, H-1), W + $urandom_range(0, 9), $urandom_range(0, 255), 2, 1'b0);
    endcase
  endtask

  // msel 0..3 fixed mode; 4 = mode 1 before pixel (2,2), mode 0 from it on.
  task automatic send_range(input int msel, input bit gaps, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int r, c, m;
      r = i / W;
      c = i % W;
      if (gaps) while ($urandom_range(0, 1) == 0) gap_cycle();
      m = (msel == 4) ? ((i < 2 * W + 2) ? 1 : 0) : msel;
      drive(1'b1, r, c, frame[r][c], m, 1'b0);
    end
  endtask

  task automatic send_frame(input int msel, input bit gaps);
    send_range(msel, gaps, 0, W * H - 1);
  endtask

  task automatic clear_caps();
    cap_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        cap_img[r][c] = -1;
  endtask

  task automatic random_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = $urandom_range(0, 255);
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        out_t o;
        e = sb.pop_front();
        check("latency_cycle", cyc, e.due);
        check("pixout", pixout, e.p);
        check("coord_row_col", longint'(rowout) * 65536 + longint'(colout),
              longint'(e.r) * 65536 + longint'(e.c));
        o.r = int'(rowout);
        o.c = int'(colout);
        o.p = int'(pixout);
        cap_q.push_back(o);
        if (o.r < H && o.c < W) cap_img[o.r][o.c] = o.p;
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("missing_out_valid", out_valid, 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    pix      = '0;
    row      = '0;
    col      = '0;
    mode     = 2'd1;
    armed_m  = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 0;
    clear_caps();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_pixout", pixout, 0);
    check("reset_rowout", rowout, 0);
    check("reset_colout", colout, 0);

    // Uniform frame
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = 'h80;
    clear_caps();
    send_frame(1, 1'b0);
    idle(6);
    check("uniform_count", cap_q.size(), 35);
    foreach (cap_q[i]) check("uniform_pix", cap_q[i].p, 'h80);
    if (cap_q.size() == 35) begin
      check("uniform_first_coord", cap_q[0].r * 65536 + cap_q[0].c, 0);
      check("uniform_last_coord", cap_q[34].r * 65536 + cap_q[34].c, 4 * 65536 + 6);
    end

    // Impulse in each mode
    for (int k = 0; k < 3; k++) begin
      int m;
      m = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          frame[r][c] = 0;
      frame[3][3] = 'hFF;
      clear_caps();
      send_frame(m, 1'b0);
      idle(6);
      check($sformatf("impulse_mode%0d", m), cap_img[3][3], (m == 0) ? 'hFF : 0);
    end

    // Vertical line at column 4
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = (c == 4) ? 'hFF : 0;
    clear_caps();
    send_frame(1, 1'b0);
    idle(6);
    for (int r = 1; r <= 4; r++) begin
      check($sformatf("vline_r%0d_c4", r), cap_img[r][4], 'hFF);
      check($sformatf("vline_r%0d_c3", r), cap_img[r][3], 0);
      check($sformatf("vline_r%0d_c5", r), cap_img[r][5], 0);
    end

    // Random frame in every mode: border pass-through
    random_frame();
    for (int m = 0; m < 4; m++) begin
      clear_caps();
      send_frame(m, 1'b0);
      idle(6);
      check($sformatf("rand_count_mode%0d", m), cap_q.size(), 35);
      foreach (cap_q[i])
        if (cap_q[i].r == 0 || cap_q[i].c == 0)
          check($sformatf("border_mode%0d", m), cap_q[i].p, frame[cap_q[i].r][cap_q[i].c]);
      if (m == 1) gold_q = cap_q;
    end

    // Throttled replay of the same frame must match the gapless mode-1 run
    clear_caps();
    send_frame(1, 1'b1);
    idle(6);
    check("throttle_count", cap_q.size(), gold_q.size());
    foreach (cap_q[i])
      if (i < gold_q.size()) begin
        check("throttle_pix", cap_q[i].p, gold_q[i].p);
        check("throttle_coord", cap_q[i].r * 65536 + cap_q[i].c,
              gold_q[i].r * 65536 + gold_q[i].c);
      end

    // Mode toggle 1 -> 0 on pixel (2,2)
    random_frame();
    clear_caps();
    send_frame(4, 1'b0);
    idle(6);
    check("toggle_centre_1_1", cap_img[1][1], frame[1][1]);

    // Reset mid-frame, resume, then new frames back to back
    random_frame();
    clear_caps();
    send_range(1, 1'b0, 0, 2 * W + 2);
    drive(1'b0, 0, 0, 0, 1, 1'b1);
    drive(1'b0, 0, 0, 0, 1, 1'b1);
    clear_caps();
    send_range(1, 1'b0, 2 * W + 3, W * H - 1);
    idle(6);
    check("post_reset_silence", cap_q.size(), 0);
    drive(1'b0, 0, 0, 0, 1, 1'b1);
    random_frame();
    clear_caps();
    send_frame(1, 1'b0);      // first pixel (0,0) shares the rst-release cycle
    random_frame();
    send_frame(2, 1'b0);
    idle(6);
    check("after_reset_two_frames_count", cap_q.size(), 70);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
